cpu_bus_ctrl: RTL

CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

---
 rtl/cpu_bus_pkg.sv | 26 ++
 rtl/bus_trace_fifo.sv | 69 ++++++
 rtl/cpu_bus_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared address map, FSM encoding and trace constants for cpu_bus_ctrl
package cpu_bus_pkg;

    localparam logic [15:0] RAM_BASE  = 16'h0000;
    localparam logic [15:0] RAM_LIMIT = 16'h1FFF;
    localparam logic [15:0] IO_BASE   = 16'h2000;
    localparam logic [15:0] IO_LIMIT  = 16'h200F;
    localparam logic [15:0] ROM_BASE  = 16'h8000;
    localparam logic [15:0] ROM_LIMIT = 16'hFFFF;
    localparam logic [15:0] ERR_CLR   = 16'h200F;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam int TRACE_W     = 25;
    localparam int TRACE_DEPTH = 8;

    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/bus_trace_fifo.sv
// rtl/bus_trace_fifo.sv - bus access trace FIFO with sticky overflow
// Ports: Clk, nRst (async active-low); push_i/data_i write side;
//        pop_i/empty_o/data_o read side (data_o shows head); ovf_o sticky drop flag.
module bus_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 25
) (
    input  logic             Clk,
    input  logic             nRst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o,
    output logic             ovf_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full || pop_i);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (do_pop && !do_push)
            count_d = count_q - 1'b1;
        ovf_d = ovf_q || (push_i && !do_push);
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= data_i;
    end

    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - CPU bus decoder/controller for RAM, IO and ROM with error capture
// Ports: Clk, nRst (async active-low); CPU side AB/DB/nRD/nWR/DB_IN;
//        RAM ram_addr/ram_wdata/ram_we/ram_rdata; ROM rom_addr/rom_rdata;
//        IO io_addr/io_wdata/io_we/io_re/io_rdata; bus_err/err_addr error capture;
//        trace_pop/trace_empty/trace_data/trace_ovf only with CPU_BUS_CTRL_TRACE_EN.
// Macro CPU_BUS_CTRL_TRACE_EN adds an 8-entry access trace FIFO.
module cpu_bus_ctrl
    import cpu_bus_pkg::*;
(
    input  logic        Clk,
    input  logic        nRst,
    input  logic [15:0] AB,
    input  logic [7:0]  DB,
    input  logic        nRD,
    input  logic        nWR,
    output logic [7:0]  DB_IN,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_rdata,
    output logic [3:0]  io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_we,
    output logic        io_re,
    input  logic [7:0]  io_rdata,
    output logic        bus_err,
    output logic [15:0] err_addr
`ifdef CPU_BUS_CTRL_TRACE_EN
    ,
    input  logic               trace_pop,
    output logic               trace_empty,
    output logic [TRACE_W-1:0] trace_data,
    output logic               trace_ovf
`endif
);
    logic [1:0]  state;
    logic        sel_ram, sel_io, sel_rom;
    logic        is_rd, is_wr, is_err;
    logic        err_hit, err_clr;
    logic [7:0]  db_in_q, db_in_d;
    logic        bus_err_q, bus_err_d;
    logic [15:0] err_addr_q, err_addr_d;
    logic        err_seen_q, err_seen_d;

    assign sel_ram = in_range(AB, RAM_BASE, RAM_LIMIT);
    assign sel_io  = in_range(AB, IO_BASE, IO_LIMIT);
    assign sel_rom = in_range(AB, ROM_BASE, ROM_LIMIT);

    // State is a pure function of the strobes each cycle; reset forces IDLE,
    // which also gates every enable low while nRst is asserted.
    always_comb begin
        state = ST_IDLE;
        if (nRst) begin
            case ({nRD, nWR})
                2'b01:   state = ST_RD;
                2'b10:   state = ST_WR;
                2'b00:   state = ST_ERR;
                default: state = ST_IDLE;
            endcase
        end
    end

    assign is_rd  = (state == ST_RD);
    assign is_wr  = (state == ST_WR);
    assign is_err = (state == ST_ERR);

    assign ram_addr  = AB[12:0];
    assign rom_addr  = AB[14:0];
    assign io_addr   = AB[3:0];
    assign ram_wdata = DB;
    assign io_wdata  = DB;
    assign ram_we    = is_wr && sel_ram;
    assign io_we     = is_wr && sel_io;
    assign io_re     = is_rd && sel_io;

    // Writes outside RAM/IO (ROM or unmapped) and strobe conflicts are errors;
    // unmapped reads are open bus and are not.
    assign err_hit = is_err || (is_wr && !sel_ram && !sel_io);
    assign err_clr = is_wr && (AB == ERR_CLR);

    always_comb begin
        db_in_d = db_in_q;
        if (is_rd) begin
            if (sel_ram)
                db_in_d = ram_rdata;
            else if (sel_io)
                db_in_d = io_rdata;
            else if (sel_rom)
                db_in_d = rom_rdata;
        end
        bus_err_d = err_clr ? 1'b0 : (bus_err_q || err_hit);
        // err_addr is captured once per reset; a clear of bus_err does not re-arm it.
        err_addr_d = (err_hit && !err_seen_q) ? AB : err_addr_q;
        err_seen_d = err_seen_q || err_hit;
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            db_in_q    <= 8'h00;
            bus_err_q  <= 1'b0;
            err_addr_q <= 16'h0000;
            err_seen_q <= 1'b0;
        end else begin
            db_in_q    <= db_in_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
            err_seen_q <= err_seen_d;
        end
    end

    assign DB_IN    = db_in_q;
    assign bus_err  = bus_err_q;
    assign err_addr = err_addr_q;

`ifdef CPU_BUS_CTRL_TRACE_EN
    // Read entries record what DB_IN is loaded with (held value on open bus).
    bus_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TRACE_W)
    ) u_trace (
        .Clk     (Clk),
        .nRst    (nRst),
        .push_i  (is_rd || is_wr),
        .data_i  ({is_rd, AB, (is_rd ? db_in_d : DB)}),
        .pop_i   (trace_pop),
        .empty_o (trace_empty),
        .data_o  (trace_data),
        .ovf_o   (trace_ovf)
    );
`endif

endmodule
